// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the MIPS pipeline.
//
// Owns the PC and keeps at most one request in flight to an instruction memory
// whose response latency varies. It holds the IF/ID pipeline register, stalls
// when the hazard unit asks, and follows branch/jump redirects.
//
// Ports:
//   clk            system clock; all state changes on the rising edge
//   reset          synchronous, active-high; beats every other input
//   stall          hazard unit request to hold IF/ID for this cycle
//   branch_taken   EX-resolved branch redirect (older, so it beats jump)
//   branch_target  branch destination; the low two bits are ignored
//   jump           ID-resolved jump redirect
//   jump_target    jump destination; the low two bits are ignored
//   imem_req       one-cycle request pulse to instruction memory
//   imem_addr      request address, always equal to the PC
//   imem_rvalid    response pulse, one per request, at least a cycle later
//   imem_rdata     instruction word, qualified by imem_rvalid
//   ifid_instr     IF/ID instruction (zero when the slot holds a bubble)
//   ifid_pc4       IF/ID PC+4 of the instruction in the slot
//   ifid_valid     IF/ID slot holds a real instruction
//   ifid_op        opcode field ifid_instr[31:26] for the control unit
//   fetch_count    number of instructions loaded into IF/ID (wraps)
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [5:0]  ifid_op,
    output logic [31:0] fetch_count
);

    // ISSUE   : request goes out this cycle
    // WAIT    : response pending and still wanted
    // HOLD    : response arrived under stall and sits in the hold buffer
    // DISCARD : response pending but stale because of a redirect
    localparam logic [1:0] ST_ISSUE   = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] hold_word_reg, hold_word_next;
    logic [31:0] ifid_instr_reg;
    logic [31:0] ifid_pc4_reg;
    logic        ifid_valid_reg;
    logic [31:0] fetch_count_reg;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic        deliver;
    logic [31:0] deliver_word;

    assign redirect        = branch_taken | jump;
    // Branch resolves in EX, so it belongs to an older instruction than an
    // ID-stage jump and takes precedence. Targets are forced word-aligned.
    assign redirect_target = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
    assign pc_plus4        = pc_reg + 32'd4;

    // Requests are suppressed during reset so the memory never sees a pulse
    // for a PC that is about to be overwritten.
    assign imem_req  = (state_reg == ST_ISSUE) && !reset;
    assign imem_addr = pc_reg;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        hold_word_next = hold_word_reg;
        deliver        = 1'b0;
        deliver_word   = hold_word_reg;

        case (state_reg)
            ST_ISSUE: begin
                if (redirect) begin
                    // The request just issued is for the old path.
                    pc_next    = redirect_target;
                    state_next = ST_DISCARD;
                end else begin
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect) begin
                        pc_next    = redirect_target;
                        state_next = ST_ISSUE;
                    end else if (stall) begin
                        hold_word_next = imem_rdata;
                        state_next     = ST_HOLD;
                    end else begin
                        deliver      = 1'b1;
                        deliver_word = imem_rdata;
                        pc_next      = pc_plus4;
                        state_next   = ST_ISSUE;
                    end
                end else if (redirect) begin
                    pc_next    = redirect_target;
                    state_next = ST_DISCARD;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    pc_next    = redirect_target;
                    state_next = ST_ISSUE;
                end else if (!stall) begin
                    deliver    = 1'b1;
                    pc_next    = pc_plus4;
                    state_next = ST_ISSUE;
                end
            end

            default: begin // ST_DISCARD
                // A later redirect replaces an earlier one; the response
                // still has to be absorbed before a new request may go out.
                if (redirect) begin
                    pc_next = redirect_target;
                end
                if (imem_rvalid) begin
                    state_next = ST_ISSUE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_ISSUE;
            pc_reg        <= RESET_PC;
            hold_word_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            hold_word_reg <= hold_word_next;
        end
    end

    // IF/ID register: flush beats hold, hold beats load, otherwise bubble.
    // pc_reg is still the address of the delivered word in a deliver cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_instr_reg  <= 32'd0;
            ifid_pc4_reg    <= 32'd0;
            ifid_valid_reg  <= 1'b0;
            fetch_count_reg <= 32'd0;
        end else if (redirect) begin
            ifid_instr_reg <= 32'd0;
            ifid_valid_reg <= 1'b0;
        end else if (stall) begin
            ifid_instr_reg <= ifid_instr_reg;
        end else if (deliver) begin
            ifid_instr_reg  <= deliver_word;
            ifid_pc4_reg    <= pc_plus4;
            ifid_valid_reg  <= 1'b1;
            fetch_count_reg <= fetch_count_reg + 32'd1;
        end else begin
            ifid_instr_reg <= 32'd0;
            ifid_valid_reg <= 1'b0;
        end
    end

    assign ifid_instr  = ifid_instr_reg;
    assign ifid_pc4    = ifid_pc4_reg;
    assign ifid_valid  = ifid_valid_reg;
    assign ifid_op     = ifid_instr_reg[31:26];
    assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// Part 1 walks a per-cycle vector table covering the directed corner cases
// (latency, stall-into-hold, redirect while waiting, double redirect, reset
// with a response in flight). Part 2 drives random stalls, redirects and
// memory latencies and checks against a transaction-level reference: the
// delivered stream must be consecutive words starting from the latest
// redirect target, and every request must be for the next word expected.
// -----------------------------------------------------------------------------
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [5:0]  ifid_op;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_bad = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid),
        .ifid_op       (ifid_op),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        stl;
        logic        bt;
        logic [31:0] btg;
        logic        jp;
        logic [31:0] jtg;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic stl, input logic bt, input logic [31:0] btg,
                       input logic jp, input logic [31:0] jtg, input logic rv, input logic [31:0] rd,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.bt = bt; v.btg = btg; v.jp = jp; v.jtg = jtg;
        v.rv = rv; v.rd = rd; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    localparam logic [31:0] W_LW   = 32'h8C01_0004;
    localparam logic [31:0] W_ADDI = 32'h2002_0005;
    localparam logic [31:0] W_ADD  = 32'h0043_2020;
    localparam logic [31:0] W_JUNK = 32'hDEAD_BEEF;
    localparam logic [31:0] W_BEQ  = 32'h1000_0003;
    localparam logic [31:0] W_OLD  = 32'hCAFE_F00D;
    localparam logic [31:0] W_SW   = 32'hAC22_0008;

    // Word stored at each address for the random phase.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] pick_target();
        if ($urandom_range(0, 7) == 0)
            return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        return $urandom & 32'h0000_0FFF;
    endfunction

    // random-phase state
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr_l;
    logic [31:0] exp_addr;
    logic        prev_redir, prev_stall, prev_valid;
    logic [31:0] prev_instr, prev_pc4, prev_cnt;
    logic        req_s;
    logic [31:0] addr_s;
    int          deliveries;

    initial begin
        //         rst stl bt btg         jp jtg         rv rd      | req addr        v  instr   pc4         cnt
        add(1, 0, 0, 0,          0, 0,          0, 0,       0, 32'h0,      0, 0,      32'h0,      0);
        add(0, 0, 0, 0,          0, 0,          0, 0,       1, 32'h0,      0, 0,      32'h0,      0);
        add(0, 0, 0, 0,          0, 0,          1, W_LW,    0, 32'h0,      0, 0,      32'h0,      0);
        add(0, 0, 0, 0,          0, 0,          0, 0,       1, 32'h4,      1, W_LW,   32'h4,      1);
        add(0, 0, 0, 0,          0, 0,          0, 0,       0, 32'h4,      0, 0,      32'h4,      1);
        add(0, 0, 0, 0,          0, 0,          0, 0,       0, 32'h4,      0, 0,      32'h4,      1);
        add(0, 0, 0, 0,          0, 0,          1, W_ADDI,  0, 32'h4,      0, 0,      32'h4,      1);
        add(0, 0, 0, 0,          0, 0,          0, 0,       1, 32'h8,      1, W_ADDI, 32'h8,      2);
        add(0, 1, 0, 0,          0, 0,          1, W_ADD,   0, 32'h8,      0, 0,      32'h8,      2);
        add(0, 1, 0, 0,          0, 0,          0, 0,       0, 32'h8,      0, 0,      32'h8,      2);
        add(0, 0, 0, 0,          0, 0,          0, 0,       0, 32'h8,      0, 0,      32'h8,      2);
        add(0, 0, 0, 0,          0, 0,          0, 0,       1, 32'hC,      1, W_ADD,  32'hC,      3);
        add(0, 0, 1, 32'h43,     0, 0,          0, 0,       0, 32'hC,      0, 0,      32'hC,      3);
        add(0, 0, 0, 0,          0, 0,          0, 0,       0, 32'h40,     0, 0,      32'hC,      3);
        add(0, 0, 0, 0,          0, 0,          1, W_JUNK,  0, 32'h40,     0, 0,      32'hC,      3);
        add(0, 0, 0, 0,          0, 0,          0, 0,       1, 32'h40,     0, 0,      32'hC,      3);
        add(0, 0, 0, 0,          0, 0,          1, W_BEQ,   0, 32'h40,     0, 0,      32'hC,      3);
        add(0, 0, 1, 32'h100,    1, 32'h200,    0, 0,       1, 32'h44,     1, W_BEQ,  32'h44,     4);
        add(0, 0, 0, 0,          1, 32'h300,    0, 0,       0, 32'h100,    0, 0,      32'h44,     4);
        add(0, 0, 0, 0,          0, 0,          1, W_OLD,   0, 32'h300,    0, 0,      32'h44,     4);
        add(0, 0, 0, 0,          0, 0,          0, 0,       1, 32'h300,    0, 0,      32'h44,     4);
        add(1, 0, 0, 0,          0, 0,          0, 0,       0, 32'h300,    0, 0,      32'h44,     4);
        add(1, 0, 0, 0,          0, 0,          1, W_SW,    0, 32'h0,      0, 0,      32'h0,      0);
        add(0, 0, 0, 0,          0, 0,          0, 0,       1, 32'h0,      0, 0,      32'h0,      0);
        add(0, 0, 0, 0,          0, 0,          1, W_LW,    0, 32'h0,      0, 0,      32'h0,      0);
        add(0, 0, 0, 0,          0, 0,          0, 0,       1, 32'h4,      1, W_LW,   32'h4,      1);
        add(0, 1, 0, 0,          1, 32'h81,     1, W_ADDI,  0, 32'h4,      0, 0,      32'h4,      1);
        add(0, 0, 0, 0,          0, 0,          0, 0,       1, 32'h80,     0, 0,      32'h4,      1);
        add(0, 0, 0, 0,          0, 0,          1, W_ADD,   0, 32'h80,     0, 0,      32'h4,      1);
        add(0, 1, 0, 0,          0, 0,          0, 0,       1, 32'h84,     1, W_ADD,  32'h84,     2);
        add(0, 0, 0, 0,          0, 0,          0, 0,       0, 32'h84,     1, W_ADD,  32'h84,     2);
        add(0, 1, 0, 0,          0, 0,          1, W_JUNK,  0, 32'h84,     0, 0,      32'h84,     2);
        add(0, 1, 1, 32'h10,     0, 0,          0, 0,       0, 32'h84,     0, 0,      32'h84,     2);
        add(0, 0, 0, 0,          0, 0,          0, 0,       1, 32'h10,     0, 0,      32'h84,     2);
        add(0, 0, 0, 0,          0, 0,          1, W_BEQ,   0, 32'h10,     0, 0,      32'h84,     2);
        add(1, 0, 0, 0,          0, 0,          0, 0,       0, 32'h14,     1, W_BEQ,  32'h14,     3);

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        jump = 1'b0; jump_target = 32'd0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- part 1: table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            reset         = vecs[i].rst;
            stall         = vecs[i].stl;
            branch_taken  = vecs[i].bt;
            branch_target = vecs[i].btg;
            jump          = vecs[i].jp;
            jump_target   = vecs[i].jtg;
            imem_rvalid   = vecs[i].rv;
            imem_rdata    = vecs[i].rd;
            @(negedge clk);
            $display("row %0d: req=%0b addr=%08h valid=%0b instr=%08h pc4=%08h count=%0d",
                     i, imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc4, fetch_count);
            chk($sformatf("row%0d_req", i),   32'(imem_req),   32'(vecs[i].e_req));
            chk($sformatf("row%0d_addr", i),  imem_addr,       vecs[i].e_addr);
            chk($sformatf("row%0d_valid", i), 32'(ifid_valid), 32'(vecs[i].e_valid));
            chk($sformatf("row%0d_instr", i), ifid_instr,      vecs[i].e_instr);
            chk($sformatf("row%0d_op", i),    32'(ifid_op),    32'(vecs[i].e_instr[31:26]));
            chk($sformatf("row%0d_pc4", i),   ifid_pc4,        vecs[i].e_pc4);
            chk($sformatf("row%0d_count", i), fetch_count,     vecs[i].e_cnt);
            @(posedge clk);
            #1;
        end

        // ---------------- part 2: random vs. reference ----------------
        // The last table row left the design in reset.
        reset      = 1'b0;
        mem_busy   = 1'b0;
        mem_cnt    = 0;
        mem_addr_l = 32'd0;
        exp_addr   = 32'h0000_0000;
        prev_redir = 1'b0;
        prev_stall = 1'b1;
        prev_valid = 1'b0;
        prev_instr = 32'd0;
        prev_pc4   = 32'd0;
        prev_cnt   = 32'd0;
        deliveries = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 19) == 0);
            jump          = ($urandom_range(0, 19) == 0);
            branch_target = pick_target();
            jump_target   = pick_target();
            if (mem_busy && mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr_l);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end

            @(negedge clk);

            // Effect of the previous clock edge on IF/ID.
            if (prev_redir) begin
                chk("rnd_flush_valid", 32'(ifid_valid), 32'd0);
                chk("rnd_flush_instr", ifid_instr, 32'd0);
                chk("rnd_flush_pc4", ifid_pc4, prev_pc4);
                chk("rnd_flush_count", fetch_count, prev_cnt);
            end else if (prev_stall) begin
                chk("rnd_hold_valid", 32'(ifid_valid), 32'(prev_valid));
                chk("rnd_hold_instr", ifid_instr, prev_instr);
                chk("rnd_hold_pc4", ifid_pc4, prev_pc4);
                chk("rnd_hold_count", fetch_count, prev_cnt);
            end else if (fetch_count !== prev_cnt) begin
                chk("rnd_dlv_count", fetch_count, prev_cnt + 32'd1);
                chk("rnd_dlv_valid", 32'(ifid_valid), 32'd1);
                chk("rnd_dlv_instr", ifid_instr, mem_word(exp_addr));
                chk("rnd_dlv_pc4", ifid_pc4, exp_addr + 32'd4);
                $display("deliver addr=%08h instr=%08h count=%0d", exp_addr, ifid_instr, fetch_count);
                exp_addr = exp_addr + 32'd4;
                deliveries++;
            end else begin
                chk("rnd_bubble_valid", 32'(ifid_valid), 32'd0);
                chk("rnd_bubble_instr", ifid_instr, 32'd0);
            end
            chk("rnd_op", 32'(ifid_op), 32'(ifid_instr[31:26]));

            req_s  = imem_req;
            addr_s = imem_addr;
            if (req_s) begin
                chk("rnd_outstanding", 32'(mem_busy), 32'd0);
                chk("rnd_req_addr", addr_s, exp_addr);
            end

            prev_redir = branch_taken | jump;
            prev_stall = stall;
            prev_valid = ifid_valid;
            prev_instr = ifid_instr;
            prev_pc4   = ifid_pc4;
            prev_cnt   = fetch_count;
            if (branch_taken)
                exp_addr = branch_target & 32'hFFFF_FFFC;
            else if (jump)
                exp_addr = jump_target & 32'hFFFF_FFFC;

            @(posedge clk);
            #1;

            if (imem_rvalid)
                mem_busy = 1'b0;
            else if (mem_busy)
                mem_cnt--;
            if (req_s) begin
                mem_busy   = 1'b1;
                mem_cnt    = $urandom_range(1, 4) - 1;
                mem_addr_l = addr_s;
            end
        end

        chk("rnd_progress", 32'(deliveries >= 50), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the MIPS pipeline. It sits directly upstream of decode and the control unit. It owns the PC, issues single-outstanding requests to a variable-latency instruction memory, and handles stalls from the hazard unit and redirects from branch/jump resolution. It drives the IF/ID pipeline register, whose ifid_op field is the opcode consumed by control.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID this cycle
branch_taken  input  1  EX-resolved branch redirect
branch_target  input  32  branch target address
jump  input  1  ID-resolved jump redirect
jump_target  input  32  jump target address
imem_req  output  1  one-cycle request pulse to instruction memory
imem_addr  output  32  request address (= PC)
imem_rvalid  input  1  response valid pulse, ≥1 cycle after imem_req
imem_rdata  input  32  instruction word, valid with imem_rvalid
ifid_instr  output  32  IF/ID instruction (0 = NOP when bubble)
ifid_pc4  output  32  IF/ID PC+4 of that instruction
ifid_valid  output  1  IF/ID holds a real instruction
ifid_op  output  6  ifid_instr[31:26], to control
fetch_count  output  32  number of valid instructions loaded into IF/ID

Behaviour:
- Reset (synchronous, wins over everything): PC=RESET_PC, state=ISSUE, ifid_instr=0, ifid_pc4=0, ifid_valid=0, fetch_count=0, instruction buffer=0. imem_req=0 during a reset cycle.
- Redirect: redirect = branch_taken | jump. Target = branch_target if branch_taken, else jump_target (branch is older and wins). Target[1:0] forced to 2'b00.
- PC arithmetic: 32-bit, PC+4 wraps modulo 2^32.
- Memory contract: one outstanding request at most; memory never backpressures. imem_addr = PC in all cycles. Exactly one imem_rvalid per request.
- FSM states: ISSUE, WAIT, HOLD, DISCARD.
  - ISSUE: imem_req=1. If redirect: PC<=target, go to DISCARD (in-flight response is stale). Else go to WAIT.
  - WAIT:
    - rvalid & redirect: drop data, PC<=target, go to ISSUE.
    - rvalid & stall: buffer<=rdata, go to HOLD.
    - rvalid, no stall: deliver rdata, PC<=PC+4, go to ISSUE.
    - No rvalid & redirect: PC<=target, go to DISCARD.
    - Else stay in WAIT.
  - HOLD:
    - redirect: drop buffer, PC<=target, go to ISSUE.
    - stall: stay in HOLD.
    - Else: deliver buffer, PC<=PC+4, go to ISSUE.
  - DISCARD:
    - redirect again: PC<=new target (latest wins).
    - rvalid: drop data, go to ISSUE.
    - Else stay in DISCARD.
- IF/ID register update priority: reset > redirect > stall > deliver > bubble.
  - Redirect: flush, ifid_valid<=0, ifid_instr<=0; ifid_pc4 unchanged.
  - Stall: IF/ID holds all fields.
  - Deliver: ifid_instr<=word, ifid_pc4<=PC+4, ifid_valid<=1, fetch_count<=fetch_count+1 (wraps).
  - Otherwise bubble: ifid_valid<=0, ifid_instr<=0.
- ifid_op is combinational from ifid_instr[31:26].
- Latency: with 1-cycle memory, instruction at PC reaches IF/ID 2 cycles after ISSUE, one instruction per 2 cycles (ISSUE→WAIT→deliver).
- Stall and redirect together: redirect wins (flush beats hold).

Test Plan:
- Reset, memory latency 1, rdata=32'h8C01_0004 → imem_req at PC=0; 2 cycles later ifid_valid=1, ifid_instr=32'h8C01_0004, ifid_op=6'h23, ifid_pc4=4; next imem_addr=4; fetch_count=1.
- Latency 3 cycles → imem_req single-cycle pulse; imem_addr stable at 0 for 3 cycles; ifid_valid=0 bubbles until delivery.
- Stall asserted the cycle rvalid arrives, held 2 cycles → FSM enters HOLD; IF/ID unchanged; on stall release the buffered word is loaded and PC advances 0→4; no extra imem_req during HOLD.
- branch_taken with target=32'h0000_0043 during WAIT, response arrives later → response dropped, ifid_valid=0; next imem_req at 32'h0000_0040; fetch_count not incremented.
- branch_taken (target 0x100) and jump (target 0x200) in the same cycle, then jump to 0x300 during DISCARD → next request at 0x300.
- Reset asserted mid-WAIT with a response pending → next cycle PC=RESET_PC, IF/ID cleared, fetch_count=0; late rvalid arriving while in ISSUE/WAIT for the new request is not delivered as a second instruction (bench waits for outstanding response before releasing reset).
